// File: rtl/var_arbiter_if.sv
// Bundle of the requester-side handshake signals and shared register outputs of var_arbiter.
// Handshake (four-phase, per port i):
//   1. Requester raises req[i] with dataIn slice i stable.
//   2. Arbiter loads dataOut and raises fin[i].
//   3. Requester drops req[i].
//   4. Arbiter drops fin[i].
// fin is one-hot or zero. req may be asynchronous to clk.
interface var_arbiter_if #(
   parameter int Width = 32,
   parameter int Ports = 4
);
   localparam int GidW = (Ports > 1) ? $clog2(Ports) : 1;

   logic [Ports-1:0]       req;
   logic [Ports*Width-1:0] dataIn;
   logic [Ports-1:0]       fin;
   logic [Width-1:0]       dataOut;
   logic                   busy;
   logic [GidW-1:0]        grantId;
   logic                   dbg_state;

   modport master (
      output req, dataIn,
      input  fin, dataOut, busy, grantId, dbg_state
   );

   modport slave (
      input  req, dataIn,
      output fin, dataOut, busy, grantId, dbg_state
   );
endinterface

// File: rtl/var_arbiter.sv
// Round-robin arbiter sharing one Width-bit register among Ports four-phase requesters.
// dbg_state exposes the FSM (0 = IDLE, 1 = ACK).
module var_arbiter #(
   parameter int               Width        = 32,
   parameter int               Ports        = 4,
   parameter logic [Width-1:0] InitialValue = '0
) (
   input logic          clk,
   input logic          rstN,
   var_arbiter_if.slave bus
);
   localparam int GidW = (Ports > 1) ? $clog2(Ports) : 1;

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t           state;
   logic [Ports-1:0] req_m;
   logic [Ports-1:0] req_s;
   logic [GidW-1:0]  last_grant;
   logic [GidW-1:0]  winner;
   logic [GidW-1:0]  idx;
   logic             found;

   // Search starts just after the last granted port and wraps around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 1; k <= Ports; k++) begin
         idx = GidW'((int'(last_grant) + k) % Ports);
         if (!found && req_s[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign bus.dbg_state = state;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         req_m       <= '0;
         req_s       <= '0;
         state       <= IDLE;
         last_grant  <= GidW'(Ports - 1);
         bus.fin     <= '0;
         bus.dataOut <= InitialValue;
         bus.busy    <= 1'b0;
         bus.grantId <= '0;
      end else begin
         req_m <= bus.req;
         req_s <= req_m;
         case (state)
            IDLE: begin
               if (found) begin
                  bus.dataOut     <= bus.dataIn[int'(winner)*Width +: Width];
                  bus.fin         <= '0;
                  bus.fin[winner] <= 1'b1;
                  bus.grantId     <= winner;
                  bus.busy        <= 1'b1;
                  state           <= ACK;
               end
            end
            ACK: begin
               // Other pending requests wait here; req is level-held so none are lost.
               if (!req_s[bus.grantId]) begin
                  bus.fin    <= '0;
                  bus.busy   <= 1'b0;
                  last_grant <= bus.grantId;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_var_arbiter.sv
// Directed bench for var_arbiter: reset, single writes, round-robin order, wrap,
// contention during ACK and reset in the middle of a handshake.
module tb_var_arbiter;
   localparam int               W    = 32;
   localparam int               P    = 4;
   localparam logic [W-1:0]     INIT = 32'h5A5A_0000;

   logic clk;
   logic rstN;
   int   checks;
   int   errors;
   logic [W-1:0] d [P];

   var_arbiter_if #(.Width(W), .Ports(P)) bus ();

   var_arbiter #(.Width(W), .Ports(P), .InitialValue(INIT)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   assign bus.dataIn = {d[3], d[2], d[1], d[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic [W-1:0] exp_data);
      chk({tag, "_fin"},   64'(bus.fin),       64'(0));
      chk({tag, "_data"},  64'(bus.dataOut),   64'(exp_data));
      chk({tag, "_busy"},  64'(bus.busy),      64'(0));
      chk({tag, "_state"}, 64'(bus.dbg_state), 64'(0));
   endtask

   // Wait (bounded) for a grant, then check it went to port p with p's data.
   task automatic await_grant(input int p, input string tag);
      int n;
      n = 0;
      while (bus.fin === '0 && n < 20) begin
         tick(1);
         n++;
      end
      chk({tag, "_fin"},  64'(bus.fin),     64'(4'b0001 << p));
      chk({tag, "_data"}, 64'(bus.dataOut), 64'(d[p]));
      chk({tag, "_gid"},  64'(bus.grantId), 64'(p));
      chk({tag, "_busy"}, 64'(bus.busy),    64'(1));
   endtask

   // Drop req[p] and check fin falls exactly two edges later.
   task automatic release_port(input int p, input string tag);
      bus.req[p] = 1'b0;
      tick(2);
      chk({tag, "_fin_hold"}, 64'(bus.fin), 64'(4'b0001 << p));
      tick(1);
      chk({tag, "_fin_drop"}, 64'(bus.fin),  64'(0));
      chk({tag, "_busy"},     64'(bus.busy), 64'(0));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstN   = 1'b0;
      bus.req = '0;
      d[0] = 32'h1000_0001;
      d[1] = 32'h2000_0002;
      d[2] = 32'hDEAD_BEEF;
      d[3] = 32'h3333_CAFE;

      // Reset values, then a quiet idle period
      tick(3);
      chk_idle("rst", INIT);
      chk("rst_gid", 64'(bus.grantId), 64'(0));
      rstN = 1'b1;
      tick(10);
      chk_idle("idle10", INIT);
      chk("idle10_gid", 64'(bus.grantId), 64'(0));

      // Single write from port 2: fin rises on the second edge after sampling
      bus.req = 4'b0100;
      tick(2);
      chk("single_pre_fin", 64'(bus.fin), 64'(0));
      tick(1);
      chk("single_fin",  64'(bus.fin),     64'(4'b0100));
      chk("single_data", 64'(bus.dataOut), 64'(32'hDEAD_BEEF));
      chk("single_gid",  64'(bus.grantId), 64'(2));
      chk("single_st",   64'(bus.dbg_state), 64'(1));
      release_port(2, "single_rel");
      tick(4);
      chk("single_held", 64'(bus.dataOut), 64'(32'hDEAD_BEEF));

      // Single write from port 3 so the next tie starts from port 0
      bus.req = 4'b1000;
      await_grant(3, "p3");
      release_port(3, "p3_rel");
      tick(2);

      // All four request together: order 0,1,2,3
      bus.req = 4'b1111;
      for (int p = 0; p < P; p++) begin
         await_grant(p, $sformatf("all_g%0d", p));
         release_port(p, $sformatf("all_r%0d", p));
      end
      tick(2);

      // Wrap: last grant was 3, so 0 wins before 3
      bus.req = 4'b1001;
      await_grant(0, "wrap_g0");
      release_port(0, "wrap_r0");
      await_grant(3, "wrap_g3");
      release_port(3, "wrap_r3");
      tick(2);

      // Contention: port 2 raises req while port 1 is in ACK
      bus.req = 4'b0010;
      await_grant(1, "cont_g1");
      bus.req[2] = 1'b1;
      tick(5);
      chk("cont_hold_fin", 64'(bus.fin), 64'(4'b0010));
      bus.req[1] = 1'b0;
      tick(2);
      chk("cont_m1_fin", 64'(bus.fin), 64'(4'b0010));
      tick(1);
      chk("cont_m2_fin", 64'(bus.fin), 64'(0));
      tick(1);
      chk("cont_m3_fin",  64'(bus.fin),     64'(4'b0100));
      chk("cont_m3_data", 64'(bus.dataOut), 64'(d[2]));
      release_port(2, "cont_r2");
      tick(2);

      // Reset in the middle of ACK with req[0] still held
      bus.req = 4'b0001;
      await_grant(0, "mid_g0");
      rstN = 1'b0;
      #1;
      chk_idle("mid_rst", INIT);
      chk("mid_rst_gid", 64'(bus.grantId), 64'(0));
      tick(2);
      rstN = 1'b1;
      tick(2);
      chk("mid_pre_fin", 64'(bus.fin), 64'(0));
      tick(1);
      chk("mid_regrant_fin",  64'(bus.fin),     64'(4'b0001));
      chk("mid_regrant_data", 64'(bus.dataOut), 64'(d[0]));
      release_port(0, "mid_r0");
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/var_arbiter.md
# var_arbiter

Clocked round-robin arbiter that shares one Width-bit register among Ports requesters, each using a four-phase req/fin handshake. A requester raises req with its data and receives fin once its data is in the register. It then drops req, and the arbiter drops fin. The block sits between asynchronous handshake producers and any consumer of the shared value. It replaces fixed-priority multi-port set registers wherever more than two writers exist or fairness is required.

## Interface
- Width, 32, bit width of each data input and of dataOut
- Ports, 4, number of requesters (2..16)
- InitialValue, 0, value of dataOut after reset
- clk  input  1  single clock; all state changes on rising edge
- rstN  input  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset
- req  input  Ports  per-requester request; asynchronous to clk; four-phase
- dataIn  input  Ports*Width  requester i data at bits [i*Width +: Width]; stable while req[i]=1
- fin  output  Ports  per-requester completion; one-hot or zero
- dataOut  output  Width  shared register value
- busy  output  1  high while a handshake is in its ACK phase
- grantId  output  clog2(Ports) (min 1)  index of current/last granted requester

## Operation
- Each req bit passes a 2-flop synchronizer (reqS). The FSM uses only reqS.
- State IDLE:
  - If any reqS bit is set, select winner g by round-robin: search starts at lastGrant+1 mod Ports and wraps.
  - On the same edge: dataOut <= dataIn slice g; fin[g] <= 1; grantId <= g; busy <= 1; state <= ACK.
- State ACK:
  - Hold dataOut, fin and grantId.
  - When reqS[g]=0: fin[g] <= 0; busy <= 0; lastGrant <= g; state <= IDLE.
  - Requests from other ports are ignored in ACK but stay pending. They are not lost because req is level-held.
- dataOut changes only on a grant edge. No other event modifies it.
- Fairness: with every port requesting continuously, grants cycle 0,1,2,…,Ports-1,0,…
  - Maximum wait for a port is Ports-1 complete handshakes.
- Reset values:
  - fin=0, dataOut=InitialValue, busy=0, grantId=0, state=IDLE.
  - lastGrant=Ports-1, so port 0 wins the first tie.
  - Synchronizers cleared.
- Reset mid-handshake: all outputs return to reset values immediately (asynchronously).
  - A requester still holding req is re-granted after release, 2 edges after synchronizer refill. dataOut is rewritten with its data.
- Requester protocol violations are outside guaranteed behaviour:
  - req pulse shorter than 2 clk periods,
  - data changing before fin,
  - req re-raise before fin falls.
- Ports=1 degenerates to a plain handshake register. grantId is constantly 0.

## Timing
- Grant latency: req[i] rises before edge k.
  - reqS[i]=1 after edge k+1.
  - At edge k+2 dataOut is loaded and fin[i] rises (if idle and i wins).
- Release latency: req[g] falls before edge m. fin[g] falls at edge m+2, and the state is IDLE after m+2.
- Back-to-back: the earliest next grant is at edge m+3, one IDLE cycle between handshakes.
- Handshake throughput with instantly responding requesters: one write per 6 clk cycles minimum.
- All outputs are registered. There are no combinational paths from req or dataIn to outputs.

## Test plan
- Reset: assert rstN=0 with InitialValue=32'h5A5A_0000 -> dataOut=32'h5A5A_0000, fin=0, busy=0, grantId=0. Release and idle 10 cycles -> no change.
- Single write: req[2]=1 with dataIn slice 2=32'hDEAD_BEEF -> fin=4'b0100 and dataOut=32'hDEAD_BEEF exactly 2 edges after sampling. Drop req[2] -> fin=0 two edges later. dataOut is held.
- Simultaneous: req=4'b1111 asserted on one edge, each requester dropping req on fin -> grant order 0,1,2,3. Each dataOut equals the granted slice. fin is never multi-hot.
- Round-robin wrap: after a grant to 3, req=4'b1001 -> port 0 granted before 3. After 0 completes, 3 is granted.
- Contention during ACK: port 1 holds ACK, port 2 raises req -> fin[2] stays 0 until fin[1] falls. Port 2 is granted at the earliest edge m+3.
- Reset mid-ACK: port 0 in ACK with fin[0]=1, pulse rstN low -> fin=0, dataOut=InitialValue at once. req[0] still high -> re-granted 2 edges after rstN rises, and dataOut is reloaded.
